// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared types and decode constants for the iterative divider
//
// Purpose: FSM state encoding for div_seq and the alucontrol codes that select
//          a divide in EX (DIV_CONTROL signed, DIVU_CONTROL unsigned).
// Ports:   none (package).
package div_seq_pkg;

  // alucontrol encodings that route an EX instruction to the divider
  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring divide iteration
//
// Purpose: shifts the next dividend bit into the partial remainder, trial
//          subtracts the divisor and restores when the result goes negative.
// Ports:
//   rem_in   in  WIDTH  partial remainder (always < divisor)
//   quo_in   in  WIDTH  dividend bits not yet consumed / quotient bits so far
//   divisor  in  WIDTH  magnitude of the divisor
//   rem_out  out WIDTH  updated partial remainder
//   quo_out  out WIDTH  shifted quotient with the new bit in the LSB
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // The shifted remainder needs WIDTH+1 bits; bit WIDTH of the difference
  // is the borrow that decides whether to restore.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle DIV/DIVU sequencer for the EX stage
//
// Purpose: latches operands, runs WIDTH restoring steps, applies the signed
//          fix-up and presents quotient (lo_o) / remainder (hi_o) with a
//          write strobe. Stalls the pipeline while the divide is in flight.
// Optional feature macro: DIV_EARLY_OUT_EN (skip the iterations when the
//          divisor is zero or |opa| < |opb|; 3-cycle latency).
// Ports:
//   clk       in  1      rising-edge clock
//   resetn    in  1      asynchronous active-low reset
//   start_i   in  1      EX holds DIV/DIVU, held while stalled
//   signed_i  in  1      1 = DIV, 0 = DIVU
//   opa_i     in  WIDTH  dividend (rs)
//   opb_i     in  WIDTH  divisor (rt)
//   annul_i   in  1      kill the EX instruction, highest priority
//   adv_i     in  1      EX advances this cycle
//   stall_o   out 1      pipeline stall request
//   ready_o   out 1      HI/LO write enable, hi_o/lo_o valid
//   lo_o      out WIDTH  quotient
//   hi_o      out WIDTH  remainder
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  input  logic             adv_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, opa_q, lo_q, hi_q;
  logic             sign_q, sign_r, div0_q, hold_q;
  logic [WIDTH-1:0] abs_a, abs_b, step_rem, step_quo;
  logic             load, last, early_go;

  assign abs_a = (signed_i & opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign abs_b = (signed_i & opb_i[WIDTH-1]) ? -opb_i : opb_i;
  assign load  = (state_q == DIV_IDLE) & start_i & ~annul_i;
  assign last  = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
  assign early_go = (opb_i == '0) || (abs_a < abs_b);
`else
  assign early_go = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= DIV_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    ready_o = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_RUN;
          stall_o = 1'b1;
        end
      end
      DIV_RUN: begin
        stall_o = 1'b1;
        if (last) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        stall_o = 1'b1;
        state_d = DIV_DONE;
      end
      DIV_DONE: begin
        // DONE always returns to IDLE so a back-to-back DIV re-latches
        ready_o = 1'b1;
        if (adv_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (annul_i) begin
      state_d = DIV_IDLE;
      stall_o = 1'b0;
      ready_o = 1'b0;
    end
    // start_i may still be high while reset is asserted; keep outputs quiet
    if (!resetn) begin
      stall_o = 1'b0;
      ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      opa_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div0_q <= 1'b0;
      hold_q <= 1'b0;
    end else if (load) begin
      opa_q  <= opa_i;
      dvs_q  <= abs_b;
      sign_q <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
      sign_r <= signed_i & opa_i[WIDTH-1];
      div0_q <= (opb_i == '0);
      // Early-out spends a single frozen RUN cycle, then goes to FIX with
      // quotient 0 and the dividend magnitude as remainder.
      hold_q <= early_go;
      cnt_q  <= early_go ? CNT_W'(WIDTH - 1) : '0;
      quo_q  <= early_go ? '0 : abs_a;
      rem_q  <= early_go ? abs_a : '0;
    end else if (state_q == DIV_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (!hold_q) begin
        quo_q <= step_quo;
        rem_q <= step_rem;
      end
    end else if (state_q == DIV_FIX && !annul_i) begin
      // Divide by zero skips the sign fix-up and reports the raw dividend
      lo_q <= div0_q ? '1    : (sign_q ? -quo_q : quo_q);
      hi_q <= div0_q ? opa_q : (sign_r ? -rem_q : rem_q);
    end
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq against an arithmetic model
module tb_div_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i, signed_i, annul_i, adv_i;
  logic [31:0] opa_i, opb_i;
  logic        stall_o, ready_o;
  logic [31:0] lo_o, hi_o;

  int errors = 0;
  int checks = 0;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .annul_i  (annul_i),
    .adv_i    (adv_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .lo_o     (lo_o),
    .hi_o     (hi_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: language-level division, with the architected special cases
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi);
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else if (s) begin
      lo = 32'($signed(a) / $signed(b));
      hi = 32'($signed(a) % $signed(b));
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // Counts cycles from the start cycle to the first ready_o; scrambles the
  // operand inputs once they are no longer supposed to matter.
  task automatic wait_ready(output int cyc, output int st);
    cyc = 0;
    st  = 0;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      if (stall_o) st++;
      if (cyc >= 1) begin
        opa_i    = $urandom;
        opb_i    = $urandom;
        signed_i = 1'($urandom);
      end
      cyc++;
      if (cyc > 200) break;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] elo, ehi;
    int cyc, st;
    ref_div(s, a, b, elo, ehi);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = s; opa_i = a; opb_i = b; adv_i = (hold == 0);
    wait_ready(cyc, st);
    check($sformatf("%s_lat", tag), cyc, 34);
    check($sformatf("%s_stall", tag), st, 34);
    check($sformatf("%s_lo", tag), lo_o, elo);
    check($sformatf("%s_hi", tag), hi_o, ehi);
    check($sformatf("%s_stall_done", tag), {31'd0, stall_o}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold_rdy", tag), {31'd0, ready_o}, 32'd1);
      check($sformatf("%s_hold_lo", tag), lo_o, elo);
    end
    adv_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, elo, ehi;
    logic        s;
    int          cyc, st;

    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0; adv_i = 1'b1;
    opa_i = '0; opb_i = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_hi", hi_o, 32'd0);

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 2);
    run_op("div_m7_2", 1'b1, -32'sd7, 32'd2, 0);
    run_op("div_7_m2", 1'b1, 32'd7, -32'sd2, 0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 0);
    run_op("div_m5_0", 1'b1, -32'sd5, 32'd0, 0);
    run_op("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    for (int k = 0; k < 24; k++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 255));
        2:       b = -32'($urandom_range(1, 255));
        default: b = a >> $urandom_range(1, 31);
      endcase
      run_op($sformatf("rnd%0d", k), s, a, b, 0);
    end

    // Annul mid-run, then a fresh divide two cycles later
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1000; opb_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    #1;
    check("annul_stall", {31'd0, stall_o}, 32'd0);
    check("annul_ready", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("annul_idle_stall", {31'd0, stall_o}, 32'd0);
    check("annul_idle_ready", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b1; opa_i = -32'sd1000; opb_i = 32'd7;
    ref_div(1'b1, -32'sd1000, 32'd7, elo, ehi);
    wait_ready(cyc, st);
    check("restart_lat", cyc, 34);
    check("restart_lo", lo_o, elo);
    check("restart_hi", hi_o, ehi);

    // Back-to-back: start_i stays high through DONE
    @(posedge clk); #1;
    signed_i = 1'b0; opa_i = 32'd12345; opb_i = 32'd99;
    ref_div(1'b0, 32'd12345, 32'd99, elo, ehi);
    wait_ready(cyc, st);
    check("b2b_lat", cyc, 34);
    check("b2b_stall", st, 34);
    check("b2b_lo", lo_o, elo);
    check("b2b_hi", hi_o, ehi);
    @(posedge clk); #1;
    start_i = 1'b0;

    // Asynchronous reset in the middle of a run
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd77; opb_i = 32'd5;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    check("arst_ready", {31'd0, ready_o}, 32'd0);
    check("arst_lo", lo_o, 32'd0);
    check("arst_hi", hi_o, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
